// File: rtl/apb_bus_arbiter_pkg.sv
// Shared definitions for the APB bus arbiter: FSM state encoding, the default
// timeout and the read value returned on a timeout abort.
package apb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort
  } arb_state_e;

  localparam int unsigned TimeoutDefault = 255;
  localparam logic [31:0] AbortRdata     = 32'h0000_0000;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: returns the first asserted request found when
// scanning upward from ptr_i, wrapping at N.
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  localparam logic [IdxW:0] NumReq = (IdxW + 1)'(N);

  logic [IdxW:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr_i < N always holds, so one conditional subtract is a full modulo
      cand = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      if (!valid_o && req_i[cand[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter funnelling several requesters onto one APB master port,
// with a BUSY-cycle timeout that aborts a hung transfer with an error pulse.
module apb_bus_arbiter
  import apb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = TimeoutDefault,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NUM_REQ-1:0]       s_req,
  input  logic [NUM_REQ-1:0]       s_write,
  input  logic [NUM_REQ-1:0][31:0] s_addr,
  input  logic [NUM_REQ-1:0][31:0] s_wdata,
  output logic [NUM_REQ-1:0]       s_ready,
  output logic [NUM_REQ-1:0]       s_err,
  output logic [31:0]              s_rdata,
  output logic                     m_req,
  output logic                     m_write,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_wdata,
  input  logic [31:0]              m_rdata,
  input  logic                     m_ready,
  output logic [IdxW-1:0]          grant_id
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  arb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] next_ptr;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic            cnt_max;

  rr_picker #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (s_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign cnt_max  = (cnt_q == CntMax);
  assign next_ptr = (grant_id == LastIdx) ? '0 : grant_id + 1'b1;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= '0;
      grant_id <= '0;
      m_req    <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            m_write  <= s_write[pick_idx];
            m_addr   <= s_addr[pick_idx];
            m_wdata  <= s_wdata[pick_idx];
            m_req    <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          // m_ready takes precedence over an expiring counter
          if (m_ready) begin
            ptr_q   <= next_ptr;
            m_req   <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_max) begin
            ptr_q   <= next_ptr;
            m_req   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StAbort;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAbort: begin
          // Wait out a late m_ready from the master so it cannot leak into the next grant
          if (m_ready || cnt_max) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    s_ready = '0;
    s_err   = '0;
    s_rdata = '0;
    if (state_q == StBusy) begin
      if (m_ready) begin
        s_ready[grant_id] = 1'b1;
        s_rdata           = m_rdata;
      end else if (cnt_max) begin
        s_ready[grant_id] = 1'b1;
        s_err[grant_id]   = 1'b1;
        s_rdata           = AbortRdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter: a driver/responder predicts each grant
// from round-robin rules and queues the expected response; a monitor checks it.
module tb_apb_bus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned T  = 8;
  localparam int unsigned IW = 1;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic [N-1:0]         s_req, s_write, s_ready, s_err;
  logic [N-1:0][31:0]   s_addr, s_wdata;
  logic [31:0]          s_rdata, m_addr, m_wdata, m_rdata;
  logic                 m_req, m_write, m_ready;
  logic [IW-1:0]        grant_id;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  // Reference model state
  int          model_ptr;
  bit          pending[N];
  logic        txn_write[N];
  logic [31:0] txn_addr[N];
  logic [31:0] txn_wdata[N];
  bit          sync_lost;

  always #5 PCLK = ~PCLK;

  apb_bus_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (T)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .s_req    (s_req),
    .s_write  (s_write),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_err    (s_err),
    .s_rdata  (s_rdata),
    .m_req    (m_req),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .grant_id (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy_ok(input int w);
    return m_req === 1'b1 && m_write === txn_write[w] && m_addr === txn_addr[w] &&
           m_wdata === txn_wdata[w] && grant_id === IW'(w);
  endfunction

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    pending[i]   = 1'b1;
    txn_write[i] = w;
    txn_addr[i]  = a;
    txn_wdata[i] = d;
    s_req[i]     = 1'b1;
    s_write[i]   = w;
    s_addr[i]    = a;
    s_wdata[i]   = d;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
  endtask

  // rmode: 0 = add nothing, 1 = every idle requester asks again, 2 = random subset (never empty)
  task automatic refill(input int rmode);
    bit any;
    any = 1'b0;
    if (rmode == 0) return;
    for (int i = 0; i < N; i++) begin
      if (!pending[i] && (rmode == 1 || $urandom_range(1, 0) == 1)) rand_req(i);
    end
    for (int i = 0; i < N; i++) any |= pending[i];
    if (!any) rand_req(int'($urandom_range(N - 1, 0)));
  endtask

  // mode: 0 = m_ready after lat BUSY cycles, 1 = m_ready on the timeout cycle,
  // 2 = timeout with silent abort, 3 = timeout with a late m_ready in ABORT cycle 'late'
  task automatic serve(input int mode, input int lat, input int late, input logic [31:0] rd,
                       input int rmode, input bit drop_early);
    int   w;
    int   waited;
    bit   stable;
    exp_t e;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (model_ptr + k) % N;
      if (w < 0 && pending[c]) w = c;
    end
    if (w < 0) begin
      miscompares++;
      $display("FAIL no_pending: got no requester to serve, expected one");
      sync_lost = 1'b1;
      return;
    end
    e.id    = w;
    e.err   = (mode >= 2);
    e.rdata = (mode >= 2) ? 32'h0 : rd;
    exp_q.push_back(e);

    @(posedge PCLK); #1;
    check("grant_gap", 32'(m_req), 32'd1);
    waited = 0;
    while (m_req !== 1'b1 && waited < 20) begin
      @(posedge PCLK); #1;
      waited++;
    end
    if (m_req !== 1'b1) begin
      miscompares++;
      $display("FAIL grant_timeout: got m_req=%b after 20 cycles, expected 1", m_req);
      sync_lost = 1'b1;
      return;
    end
    check("grant_id", 32'(grant_id), 32'(w));
    check("m_write", 32'(m_write), 32'(txn_write[w]));
    check("m_addr", m_addr, txn_addr[w]);
    check("m_wdata", m_wdata, txn_wdata[w]);
    if (drop_early) s_req[w] = 1'b0;

    stable = 1'b1;
    if (mode < 2) begin
      repeat (lat) begin
        @(posedge PCLK); #1;
        stable &= busy_ok(w);
      end
      m_ready = 1'b1;
      m_rdata = rd;
      @(posedge PCLK); #1;
      m_ready     = 1'b0;
      m_rdata     = $urandom;
      s_req[w]    = 1'b0;
      pending[w]  = 1'b0;
      model_ptr   = (w + 1) % N;
      check("hold_stable", 32'(stable), 32'd1);
      check("m_req_drop", 32'(m_req), 32'd0);
      refill(rmode);
    end else begin
      repeat (T) begin
        @(posedge PCLK); #1;
        stable &= busy_ok(w);
      end
      @(posedge PCLK); #1;
      s_req[w]   = 1'b0;
      pending[w] = 1'b0;
      model_ptr  = (w + 1) % N;
      check("hold_stable", 32'(stable), 32'd1);
      refill(rmode);
      for (int k = 0; k <= int'(T); k++) begin
        check("abort_m_req", 32'(m_req), 32'd0);
        if (k == late) begin
          m_ready = 1'b1;
          m_rdata = $urandom;
        end
        @(posedge PCLK); #1;
        m_ready = 1'b0;
        if (k == late) break;
      end
    end
  endtask

  // Monitor: every s_ready/s_err activity must match the oldest expected response
  always @(negedge PCLK) begin
    exp_t e;
    if (s_ready !== '0 || s_err !== '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got s_ready=%b s_err=%b, expected none", s_ready, s_err);
      end else begin
        e = exp_q.pop_front();
        check("s_ready", 32'(s_ready), 32'(1) << e.id);
        check("s_err", 32'(s_err), e.err ? (32'(1) << e.id) : 32'(0));
        check("s_rdata", s_rdata, e.rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    PRESET    = 1'b1;
    s_req     = '0;
    s_write   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_ready   = 1'b1;
    m_rdata   = 32'hFFFF_FFFF;
    model_ptr = 0;
    sync_lost = 1'b0;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    #1 PRESET = 1'b0;

    // Reset state, with m_ready/m_rdata active to prove the outputs are gated
    repeat (2) @(negedge PCLK);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_s_err", 32'(s_err), 32'd0);
    check("rst_s_rdata", s_rdata, 32'd0);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge PCLK); #1;
    m_ready = 1'b0;
    PRESET  = 1'b1;
    @(posedge PCLK); #1;

    // Single write, m_ready three cycles into BUSY
    set_req(0, 1'b1, 32'h1000_2000, 32'h0000_00A5);
    serve(0, 3, -1, 32'h0, 0, 1'b0);

    // Reset in the middle of a BUSY transfer for requester 1
    set_req(1, 1'b0, $urandom, $urandom);
    @(posedge PCLK); #1;
    check("pre_rst_m_req", 32'(m_req), 32'd1);
    check("pre_rst_grant", 32'(grant_id), 32'd1);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    #1;
    check("mid_rst_m_req", 32'(m_req), 32'd0);
    s_req = '0;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    model_ptr = 0;
    @(negedge PCLK);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge PCLK);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    rand_req(0);
    rand_req(1);
    serve(0, int'($urandom_range(3, 0)), -1, $urandom, 0, 1'b0);

    // Read by requester 1 (still pending after the post-reset grant)
    set_req(1, 1'b0, 32'h2000_0040, 32'h0);
    serve(0, 2, -1, 32'hDEAD_BEEF, 0, 1'b0);

    // Timeout with a silent master, then tie, then a late m_ready during ABORT
    rand_req(0);
    serve(2, 0, -1, 32'h0, 0, 1'b0);
    rand_req(1);
    serve(1, int'(T), -1, $urandom, 0, 1'b0);
    rand_req(0);
    serve(3, 0, int'($urandom_range(T - 1, 0)), 32'h0, 0, 1'b0);
    rand_req(1);
    serve(0, 1, -1, $urandom, 0, 1'b1);

    // Continuous contention: grants must alternate
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 4 && !sync_lost; i++) begin
      serve(0, int'($urandom_range(4, 0)), -1, $urandom, 1, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 150 && !sync_lost; i++) begin
      r = int'($urandom_range(9, 0));
      if (r < 7)       serve(0, int'($urandom_range(T - 1, 0)), -1, $urandom, 2,
                             $urandom_range(3, 0) == 0);
      else if (r == 7) serve(1, int'(T), -1, $urandom, 2, 1'b0);
      else if (r == 8) serve(2, 0, -1, 32'h0, 2, 1'b0);
      else             serve(3, 0, int'($urandom_range(T, 0)), 32'h0, 2, 1'b0);
    end

    repeat (3) @(posedge PCLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
